// File: rtl/div_issue.sv
// div_issue: issues one tagged divide request at a time to the integer divider and
// holds the result for writeback. Optional macro DIV_ZERO_BYPASS_EN answers x/0 locally.
`default_nettype none

module div_issue #(
  parameter int BW   = 32,
  parameter int REGW = 5
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_clear,
  // upstream request
  input  logic            i_stb,
  output logic            o_ready,
  input  logic            i_signed,
  input  logic [BW-1:0]   i_numerator,
  input  logic [BW-1:0]   i_denominator,
  input  logic [REGW-1:0] i_dreg,
  // divider side
  output logic            o_div_wr,
  output logic            o_div_signed,
  output logic [BW-1:0]   o_div_num,
  output logic [BW-1:0]   o_div_den,
  input  logic            i_div_busy,
  input  logic            i_div_valid,
  input  logic            i_div_err,
  input  logic [BW-1:0]   i_div_quotient,
  input  logic [3:0]      i_div_flags,
  // writeback side
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_err,
  output logic [BW-1:0]   o_result,
  output logic [3:0]      o_flags,
  output logic [REGW-1:0] o_dreg,
  output logic            o_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   capture;
  logic   zero_den;

  // Ownership is fully tracked by the state machine, so divider busy is not consulted.
  logic unused_busy;
  assign unused_busy = i_div_busy;

`ifdef DIV_ZERO_BYPASS_EN
  assign zero_den = (i_denominator == '0);
`else
  assign zero_den = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE:  o_ready = !i_reset && !i_clear;
      S_DONE:  o_ready = !i_reset && i_ready && !i_clear;
      default: o_ready = 1'b0;
    endcase
    accept = i_stb && o_ready;

    case (state)
      S_IDLE: begin
        if (accept)
          state_nxt = zero_den ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        state_nxt = i_clear ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (i_div_valid) begin
          if (i_clear) begin
            state_nxt = S_IDLE;
          end else begin
            capture   = 1'b1;
            state_nxt = S_DONE;
          end
        end else if (i_clear) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (i_div_valid)
          state_nxt = S_IDLE;
      end
      S_DONE: begin
        // Clear wins over writeback; accept-on-drain keeps back-to-back throughput.
        if (i_clear)
          state_nxt = S_IDLE;
        else if (accept)
          state_nxt = zero_den ? S_DONE : S_ISSUE;
        else if (i_ready)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_div_signed <= 1'b0;
      o_div_num    <= '0;
      o_div_den    <= '0;
      o_dreg       <= '0;
      o_result     <= '0;
      o_err        <= 1'b0;
      o_flags      <= '0;
    end else begin
      if (accept) begin
        o_div_signed <= i_signed;
        o_div_num    <= i_numerator;
        o_div_den    <= i_denominator;
        o_dreg       <= i_dreg;
        if (zero_den) begin
          o_result <= '0;
          o_err    <= 1'b1;
          o_flags  <= '0;
        end
      end
      if (capture) begin
        o_result <= i_div_quotient;
        o_err    <= i_div_err;
        o_flags  <= i_div_flags;
      end
    end
  end

  assign o_div_wr = (state == S_ISSUE);
  assign o_valid  = (state == S_DONE);
  assign o_busy   = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_div_issue.sv
// tb_div_issue: directed and randomized checks of div_issue against a
// transaction-level model and a simple latency-programmable divider.
`default_nettype none
`timescale 1ns/1ps

module tb_div_issue;
  localparam int BW   = 32;
  localparam int REGW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, clr, stb, sgn, rdy;
  logic [BW-1:0]   num, den;
  logic [REGW-1:0] dreg;
  logic            div_busy, div_valid, div_err;
  logic [BW-1:0]   div_q;
  logic [3:0]      div_flags;

  logic            o_ready, o_div_wr, o_div_signed, o_valid, o_err, o_busy;
  logic [BW-1:0]   o_div_num, o_div_den, o_result;
  logic [3:0]      o_flags;
  logic [REGW-1:0] o_dreg;

  div_issue #(.BW(BW), .REGW(REGW)) dut (
    .i_clk(clk), .i_reset(rst), .i_clear(clr),
    .i_stb(stb), .o_ready(o_ready), .i_signed(sgn),
    .i_numerator(num), .i_denominator(den), .i_dreg(dreg),
    .o_div_wr(o_div_wr), .o_div_signed(o_div_signed),
    .o_div_num(o_div_num), .o_div_den(o_div_den),
    .i_div_busy(div_busy), .i_div_valid(div_valid), .i_div_err(div_err),
    .i_div_quotient(div_q), .i_div_flags(div_flags),
    .o_valid(o_valid), .i_ready(rdy), .o_err(o_err), .o_result(o_result),
    .o_flags(o_flags), .o_dreg(o_dreg), .o_busy(o_busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference divide: returns {err, flags, quotient}; flags = {0, 0, negative, zero}.
  function automatic logic [BW+4:0] ref_div(input logic s, input logic [BW-1:0] n, input logic [BW-1:0] d);
    logic [BW-1:0] q;
    logic          e;
    e = 1'b0;
    if (d == '0) begin
      q = '0;
      e = 1'b1;
    end else if (s) begin
      if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) q = n;
      else q = $signed(n) / $signed(d);
    end else begin
      q = n / d;
    end
    return {e, 2'b00, q[BW-1], (q == '0), q};
  endfunction

  // Divider: start on write strobe, busy for 'lat' cycles, result strobe in the last one.
  int   cnt = 0;
  logic fixed_lat;
  assign div_busy  = (cnt != 0);
  assign div_valid = (cnt == 1);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      cnt <= 0;
    end else if (o_div_wr) begin
      cnt <= fixed_lat ? 5 : int'($urandom_range(1, 6));
      {div_err, div_flags, div_q} <= ref_div(o_div_signed, o_div_num, o_div_den);
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
    end
  end

  // Transaction model: owned request, pending result, result-to-be-discarded.
  logic            m_have = 0, m_pend = 0, m_wr = 0, m_doom = 0, m_sgn = 0, m_err = 0;
  logic [BW-1:0]   m_num = 0, m_den = 0, m_res = 0;
  logic [REGW-1:0] m_dreg = 0;
  logic [3:0]      m_flags = 0;
  bit              started = 0;

  function automatic logic exp_ready();
    return !rst && !clr && (!m_have || (m_pend && rdy));
  endfunction

  always @(posedge clk) begin
    logic acc, zd;
    started = 1;
    if (rst) begin
      m_have = 0; m_pend = 0; m_wr = 0; m_doom = 0; m_sgn = 0; m_err = 0;
      m_num = 0; m_den = 0; m_res = 0; m_dreg = 0; m_flags = 0;
    end else begin
      acc = stb && exp_ready();
      if (m_pend) begin
        if (clr || rdy) begin m_pend = 0; m_have = 0; end
      end else if (m_have) begin
        if (div_valid) begin
          if (m_doom || clr) begin
            m_have = 0; m_doom = 0;
          end else begin
            {m_err, m_flags, m_res} = ref_div(m_sgn, m_num, m_den);
            m_pend = 1;
          end
        end else if (clr) begin
          m_doom = 1;
        end
      end
      m_wr = 0;
      if (acc) begin
        m_have = 1; m_doom = 0;
        m_sgn = sgn; m_num = num; m_den = den; m_dreg = dreg;
        zd = 0;
`ifdef DIV_ZERO_BYPASS_EN
        zd = (den == '0);
`endif
        if (zd) begin
          m_pend = 1; m_res = '0; m_err = 1; m_flags = '0;
        end else begin
          m_wr = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("valid",   o_valid,      m_pend);
      chk("busy",    o_busy,       m_have);
      chk("div_wr",  o_div_wr,     m_wr);
      chk("ready",   o_ready,      exp_ready());
      chk("div_num", o_div_num,    m_num);
      chk("div_den", o_div_den,    m_den);
      chk("div_sgn", o_div_signed, m_sgn);
      chk("dreg",    o_dreg,       m_dreg);
      chk("result",  o_result,     m_res);
      chk("err",     o_err,        m_err);
      chk("flags",   o_flags,      m_flags);
      if (div_valid) chk("proto_div_valid_owned", m_have && !m_pend, 1);
      if (o_div_wr)  chk("wr_while_busy", div_busy, 0);
    end
  end

  task automatic send(input logic s, input logic [BW-1:0] n, input logic [BW-1:0] d,
                      input logic [REGW-1:0] r, output int acc_cyc);
    stb = 1; sgn = s; num = n; den = d; dreg = r; acc_cyc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_ready) begin
        @(posedge clk);
        acc_cyc = cyc;
        #1 stb = 0;
        break;
      end
    end
    if (acc_cyc < 0) chk("send_timeout", 1, 0);
  endtask

  task automatic wait_valid(output int vc, output int nwr);
    vc = -1; nwr = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_div_wr) nwr++;
      if (o_valid) begin vc = cyc; break; end
    end
    if (vc < 0) chk("valid_timeout", 1, 0);
  endtask

  initial begin
    int a, vc, nwr;
    rst = 1; clr = 0; stb = 0; sgn = 0; num = 0; den = 0; dreg = 0; rdy = 0; fixed_lat = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_busy",  o_busy,  0);
    @(posedge clk); #1 rst = 0;

    // Unsigned 100/7 into r3 with a 5-cycle divider.
    send(0, 100, 7, 3, a);
    wait_valid(vc, nwr);
    chk("t1_latency", vc - a, 7);
    chk("t1_wr_pulses", nwr, 1);
    chk("t1_result", o_result, 14);
    chk("t1_err", o_err, 0);
    chk("t1_dreg", o_dreg, 3);

    // Writeback stalls for 6 cycles while a new request waits upstream.
    @(posedge clk); #1;
    stb = 1; sgn = 1; num = 32'hFFFF_FF9C; den = 7; dreg = 9;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("hold_ready", o_ready, 0);
      chk("hold_valid", o_valid, 1);
      chk("hold_result", o_result, 14);
      chk("hold_dreg", o_dreg, 3);
      @(posedge clk); #1;
    end
    rdy = 1;
    @(negedge clk);
    chk("accept_on_drain_ready", o_ready, 1);
    @(posedge clk); a = cyc; #1 stb = 0; rdy = 0;
    @(negedge clk);
    chk("t2_wr", o_div_wr, 1);
    chk("t2_valid", o_valid, 0);
    wait_valid(vc, nwr);
    chk("t2_latency", vc - a, 7);
    chk("t2_result", o_result, 32'hFFFF_FFF2);
    chk("t2_flag_neg", o_flags[1], 1);
    chk("t2_flag3", o_flags[3], 0);
    chk("t2_dreg", o_dreg, 9);
    @(posedge clk); #1 rdy = 1;

    // Flush one cycle into WAIT: result must be dropped.
    send(0, 1000, 3, 4, a);
    @(posedge clk); #1;
    @(posedge clk); #1 clr = 1;
    @(posedge clk); #1 clr = 0;
    vc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("drain_valid", o_valid, 0);
      chk("drain_ready", o_ready, 0);
      if (div_valid) begin vc = cyc; break; end
    end
    chk("drain_saw_div_valid", vc >= 0, 1);
    @(negedge clk);
    chk("drain_ready_back", o_ready, 1);
    chk("drain_no_valid", o_valid, 0);
    @(posedge clk); #1;

    // Divide by zero.
    send(0, 5, 0, 7, a);
`ifdef DIV_ZERO_BYPASS_EN
    @(negedge clk);
    chk("dz_valid", o_valid, 1);
    chk("dz_err", o_err, 1);
    chk("dz_result", o_result, 0);
    chk("dz_wr", o_div_wr, 0);
    nwr = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (o_div_wr) nwr++; end
    chk("dz_no_wr", nwr, 0);
`else
    wait_valid(vc, nwr);
    chk("dz_wr_pulses", nwr, 1);
    chk("dz_err", o_err, 1);
`endif
    @(posedge clk); #1;

    // Reset while waiting on the divider.
    send(0, 77, 5, 2, a);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_valid", o_valid, 0);
    chk("rw_busy", o_busy, 0);
    chk("rw_ready", o_ready, 0);
    chk("rw_num", o_div_num, 0);
    chk("rw_dreg", o_dreg, 0);
    chk("rw_result", o_result, 0);
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); chk("rw_no_valid", o_valid, 0); end
    @(posedge clk); #1;

    // Randomized traffic.
    fixed_lat = 0;
    for (int i = 0; i < 3000; i++) begin
      stb = ($urandom_range(0, 2) != 0);
      sgn = $urandom_range(0, 1);
      num = $urandom;
      case ($urandom_range(0, 3))
        0:       den = '0;
        1:       den = $urandom_range(1, 9);
        2:       den = 32'(0 - $urandom_range(1, 9));
        default: den = $urandom;
      endcase
      dreg = REGW'($urandom);
      clr  = ($urandom_range(0, 15) == 0);
      rdy  = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    stb = 0; clr = 0; rst = 0; rdy = 1;
    repeat (12) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
